// File: rtl/sram_like_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sram_like_responder_if                                 |
// | Description : SRAM-like request/response bundle between a CPU port    |
// |               (master) and the memory-side responder (slave).         |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface sram_like_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        stall_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata, stall_addr,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata, stall_addr,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_like_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sram_like_responder                                    |
// | Description : Memory-side responder for the SRAM-like bus. Accesses   |
// |               an internal word RAM at address acceptance and returns  |
// |               in-order responses LATENCY cycles later through a       |
// |               bounded outstanding-request queue.                      |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module sram_like_responder #(
  parameter int AW      = 12,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_like_responder_if.slave bus
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AGW = $clog2(LATENCY + 1);
  localparam logic [AGW-1:0] C_AGE_MAX = AGW'(LATENCY);
  localparam logic [CW-1:0]  C_DEPTH   = CW'(DEPTH);

  // Word RAM; deliberately not reset so accepted writes survive a reset.
  logic [31:0] mem_q [2**AW];

  // Outstanding-request queue. Write responses carry zero data, so rdata
  // needs no separate read/write flag.
  logic [31:0]    data_q [DEPTH];
  logic [31:0]    data_d [DEPTH];
  logic [AGW-1:0] age_q  [DEPTH];
  logic [AGW-1:0] age_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;

  logic [AW-1:0]  word_idx;
  logic [31:0]    merged_word;
  logic           addr_ok_w;
  logic           data_ok_w;
  logic           accept;
  logic           pop;
  logic           unused_bits;

  assign word_idx = bus.addr[AW+1:2];

  // Bits of the request that never influence the access.
  assign unused_bits = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0]};

  // addr_ok looks only at pre-edge occupancy, so a full queue refuses
  // requests even in a cycle where the head is popping.
  assign addr_ok_w = ~reset & ~bus.stall_addr & (count_q < C_DEPTH);
  assign data_ok_w = valid_q[head_q] & (age_q[head_q] >= C_AGE_MAX);
  assign accept    = bus.req & addr_ok_w;
  assign pop       = data_ok_w;

  assign bus.addr_ok = addr_ok_w;
  assign bus.data_ok = data_ok_w;
  assign bus.rdata   = data_ok_w ? data_q[head_q] : 32'h0;

  // Byte-lane merge of write data into the currently addressed word.
  always_comb begin
    merged_word = mem_q[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (bus.wstrb[i]) merged_word[8*i +: 8] = bus.wdata[8*i +: 8];
    end
  end

  // RAM write on accepted write requests.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) mem_q[word_idx] <= merged_word;
  end

  // Queue next state: age every live entry, pop the head, push at tail.
  always_comb begin
    data_d  = data_q;
    age_d   = age_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (age_q[i] != C_AGE_MAX)) age_d[i] = age_q[i] + 1'b1;
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      age_d[head_q]   = '0;
      head_d          = head_q + 1'b1;
    end

    // Tail never equals a popping head here: pop needs count > 0 and
    // accept needs count < DEPTH.
    if (accept) begin
      valid_d[tail_q] = 1'b1;
      age_d[tail_q]   = AGW'(1);
      data_d[tail_q]  = bus.wr ? 32'h0 : mem_q[word_idx];
      tail_d          = tail_q + 1'b1;
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue registers; reset discards all in-flight responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '{default: '0};
      age_q   <= '{default: '0};
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      age_q   <= age_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/sram_like_responder.md
# sram_like_responder

Memory-side responder for the CPU's SRAM-like request/response interface (req/wr/size/addr/wstrb/wdata → addr_ok/data_ok/rdata). One instance serves the instruction port and one serves the data port in core-level simulation and FPGA bring-up without the AXI bridge. It accepts address-phase handshakes, performs the access against an internal word-addressed RAM, and returns in-order responses after a programmable latency. An outstanding-request queue bounds in-flight accesses and generates address-phase backpressure.

## Interface
- AW, 12: RAM index width in bits; capacity 2^AW 32-bit words.
- LATENCY, 2: cycles from address acceptance to data_ok; legal range ≥1.
- DEPTH, 4: maximum outstanding requests; power of two, ≥2.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = half, 2 = word; informational only, wstrb governs writes.
- addr  in  32  byte address; word index = addr[AW+1:2]; other bits ignored.
- wstrb  in  4  byte enables for writes.
- wdata  in  32  write data.
- stall_addr  in  1  test hook; forces addr_ok low while high.
- addr_ok  out  1  request accepted this cycle when req is also high.
- data_ok  out  1  response valid this cycle, one cycle per request.
- rdata  out  32  read data, valid with data_ok.

## Operation
- Accept: handshake = req & addr_ok at a rising edge. addr_ok = ~reset & ~stall_addr & (count < DEPTH), purely combinational from state and stall_addr, independent of req.
- On accept, RAM is accessed in the same edge: write merges wdata into word addr[AW+1:2] per wstrb bit (bit i → byte i); read captures the full word into the new queue entry. Accesses therefore take effect in acceptance order; a read accepted after a write to the same word returns the new data.
- Queue: circular FIFO of DEPTH entries {rdata, age}. New entry written at tail with age = 1. Each edge every valid entry's age increments, saturating at LATENCY.
- Response: data_ok = head valid & head age ≥ LATENCY (combinational from registers). rdata = head entry data when data_ok and entry is a read; 0 for writes and when data_ok low.
- Pop: head removed on every edge where data_ok is high; no backpressure on response channel.
- Count: count' = count + accept − pop; accept and pop in the same edge leave count unchanged. Because addr_ok uses pre-edge count, a full queue blocks acceptance even in a pop cycle.
- Pointers wrap modulo DEPTH.
- Reset: queue emptied (count = 0, pointers 0, ages 0); RAM contents not reset.

## Timing
- Reset values: addr_ok 0 (during reset), data_ok 0, rdata 0; addr_ok rises the first cycle after reset deasserts if stall_addr low.
- Request accepted in cycle T → data_ok high in cycle T+LATENCY exactly, provided no older response is pending; responses always in acceptance order.
- Throughput: one accept and one response per cycle sustained when DEPTH ≥ LATENCY+1; otherwise limited to DEPTH accepts per LATENCY+1 cycles.
- stall_addr asserted mid-burst: no new accepts; queued responses continue draining on schedule.
- Reset asserted while requests in flight: pending responses discarded, no data_ok after the reset edge; RAM writes already accepted persist.
- wstrb = 0 on write: no RAM change, data_ok still returned.

## Test plan
- Write 0xDEADBEEF, wstrb 0xF, addr 0x100 in cycle 5; read addr 0x100 cycle 6 (LATENCY=2) → data_ok cycles 7 and 8, rdata 0 then 0xDEADBEEF.
- Word 0x0 = 0x11223344; byte write wdata 0x000000AA wstrb 0x1, then half write wdata 0xBBBB0000 wstrb 0xC → read returns 0xBBBB33AA.
- LATENCY=2, DEPTH=4: four back-to-back reads cycles 10–13 → addr_ok high throughout, data_ok cycles 12–15, data in order.
- LATENCY=4, DEPTH=2: req held high from cycle 0 → accepts cycles 0,1; addr_ok low cycles 2–4; data_ok cycles 4,5; next accept cycle 5.
- stall_addr high cycles 3–6 with req high → no accepts, addr_ok low, previously accepted response still at T+LATENCY.
- Three reads accepted, reset high one cycle before first data_ok → data_ok never asserts for them; addr_ok low in reset cycle, high next cycle; prior written data intact on re-read.
